// File: rtl/max_scanner.sv
// max_scanner: sequential max-finder over CH_N value/payload channels.
// Scans PAR channels per cycle and reports the highest value strictly above
// a per-scan threshold, with its payload and channel index. On equal values
// the lowest channel index wins.
module max_scanner #(
    parameter int CH_N  = 8,
    parameter int VAL_W = 3,
    parameter int PLD_W = 1,
    parameter int PAR   = 2,
    localparam int IDX_W = (CH_N > 1) ? $clog2(CH_N) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic [VAL_W-1:0]        i_thres,
    input  logic [CH_N*VAL_W-1:0]   i_val,
    input  logic [CH_N*PLD_W-1:0]   i_pld,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_found,
    output logic [VAL_W-1:0]        o_val,
    output logic [PLD_W-1:0]        o_pld,
    output logic [IDX_W-1:0]        o_idx
);

    // Number of scan steps and the counter that walks them.
    localparam int S     = (CH_N + PAR - 1) / PAR;
    localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
    localparam int TOT   = S * PAR;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(S - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VAL_W-1:0]   best_val_q, best_val_d;
    logic [PLD_W-1:0]   best_pld_q, best_pld_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic               found_q, found_d;
    logic               res_found_q, res_found_d;
    logic [VAL_W-1:0]   res_val_q, res_val_d;
    logic [PLD_W-1:0]   res_pld_q, res_pld_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;

    // Inputs padded to a whole number of groups so every lane select stays
    // in range; padded lanes are excluded from the group max below.
    logic [TOT*VAL_W-1:0] val_pad;
    logic [TOT*PLD_W-1:0] pld_pad;

    genvar gi;
    generate
        for (gi = 0; gi < TOT; gi++) begin : g_pad
            if (gi < CH_N) begin : g_real
                assign val_pad[gi*VAL_W +: VAL_W] = i_val[gi*VAL_W +: VAL_W];
                assign pld_pad[gi*PLD_W +: PLD_W] = i_pld[gi*PLD_W +: PLD_W];
            end else begin : g_fill
                assign val_pad[gi*VAL_W +: VAL_W] = '0;
                assign pld_pad[gi*PLD_W +: PLD_W] = '0;
            end
        end
    endgenerate

    logic [VAL_W-1:0] grp_val;
    logic [PLD_W-1:0] grp_pld;
    logic [IDX_W-1:0] grp_idx;

    // Max of the current group; lanes are visited low to high and only a
    // strictly larger value replaces, so the lowest index wins a tie.
    always_comb begin
        int base;
        int ch;
        int best_ch;
        base    = int'(cnt_q) * PAR;
        best_ch = base;
        grp_val = val_pad[base*VAL_W +: VAL_W];
        grp_pld = pld_pad[base*PLD_W +: PLD_W];
        for (int l = 1; l < PAR; l++) begin
            ch = base + l;
            if (ch < CH_N && val_pad[ch*VAL_W +: VAL_W] > grp_val) begin
                grp_val = val_pad[ch*VAL_W +: VAL_W];
                grp_pld = pld_pad[ch*PLD_W +: PLD_W];
                best_ch = ch;
            end
        end
        grp_idx = IDX_W'(best_ch);
    end

    // Next-state logic: scan sequencing, running best and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_val_d  = best_val_q;
        best_pld_d  = best_pld_q;
        best_idx_d  = best_idx_q;
        found_d     = found_q;
        res_found_d = res_found_q;
        res_val_d   = res_val_q;
        res_pld_d   = res_pld_q;
        res_idx_d   = res_idx_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (i_start) begin
                    // Seeding the running best with the threshold makes the
                    // strict compare reject values equal to the threshold.
                    state_d    = ST_SCAN;
                    cnt_d      = '0;
                    best_val_d = i_thres;
                    best_pld_d = '0;
                    best_idx_d = '0;
                    found_d    = 1'b0;
                end
            end
            ST_SCAN: begin
                // Strict compare keeps the earlier group on cross-group ties.
                if (grp_val > best_val_q) begin
                    best_val_d = grp_val;
                    best_pld_d = grp_pld;
                    best_idx_d = grp_idx;
                    found_d    = 1'b1;
                end
                if (cnt_q == LAST_GRP) begin
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    res_found_d = found_d;
                    res_val_d   = found_d ? best_val_d : '0;
                    res_pld_d   = found_d ? best_pld_d : '0;
                    res_idx_d   = found_d ? best_idx_d : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            best_val_q  <= '0;
            best_pld_q  <= '0;
            best_idx_q  <= '0;
            found_q     <= 1'b0;
            res_found_q <= 1'b0;
            res_val_q   <= '0;
            res_pld_q   <= '0;
            res_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_val_q  <= best_val_d;
            best_pld_q  <= best_pld_d;
            best_idx_q  <= best_idx_d;
            found_q     <= found_d;
            res_found_q <= res_found_d;
            res_val_q   <= res_val_d;
            res_pld_q   <= res_pld_d;
            res_idx_q   <= res_idx_d;
        end
    end

    assign o_busy  = (state_q == ST_SCAN);
    assign o_done  = (state_q == ST_DONE);
    assign o_found = res_found_q;
    assign o_val   = res_val_q;
    assign o_pld   = res_pld_q;
    assign o_idx   = res_idx_q;

endmodule

// File: tb/tb_max_scanner.sv
// Testbench for max_scanner: randomized and directed scans on an 8-channel,
// 2-lane instance checked through a scoreboard, plus directed checks of a
// partial-last-group instance and a single-step instance.
module tb_max_scanner;

    localparam int S = 4;   // steps for CH_N=8, PAR=2

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic       start = 1'b0;
    logic [2:0] thres = '0;
    logic [23:0] val = '0;
    logic [7:0] pld = '0;
    logic       busy, done, found, opld;
    logic [2:0] oval, oidx;

    // secondary instances
    logic       s2 = 1'b0;
    logic [2:0] thres2 = '0;
    logic [14:0] val5 = '0;
    logic [4:0] pld5 = '0;
    logic [23:0] val8 = '0;
    logic [7:0] pld8 = '0;
    logic       b5, d5, f5, p5o, b8, d8, f8, p8o;
    logic [2:0] v5o, i5o, v8o, i8o;

    max_scanner #(.CH_N(8), .VAL_W(3), .PLD_W(1), .PAR(2)) dut (
        .clk(clk), .rstn(rstn), .i_start(start), .i_thres(thres),
        .i_val(val), .i_pld(pld), .o_busy(busy), .o_done(done),
        .o_found(found), .o_val(oval), .o_pld(opld), .o_idx(oidx));

    max_scanner #(.CH_N(5), .VAL_W(3), .PLD_W(1), .PAR(2)) dut5 (
        .clk(clk), .rstn(rstn), .i_start(s2), .i_thres(thres2),
        .i_val(val5), .i_pld(pld5), .o_busy(b5), .o_done(d5),
        .o_found(f5), .o_val(v5o), .o_pld(p5o), .o_idx(i5o));

    max_scanner #(.CH_N(8), .VAL_W(3), .PLD_W(1), .PAR(8)) dut8 (
        .clk(clk), .rstn(rstn), .i_start(s2), .i_thres(thres2),
        .i_val(val8), .i_pld(pld8), .o_busy(b8), .o_done(d8),
        .o_found(f8), .o_val(v8o), .o_pld(p8o), .o_idx(i8o));

    typedef struct {
        int   st;
        int   dn;
        logic f;
        int   v;
        int   p;
        int   i;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   tv[8];
    int   tp[8];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference: highest value strictly above threshold, lowest index on ties.
    function automatic void ref_scan(input int n, input int v[8], input int p[8],
                                     input int thr, output logic f,
                                     output int bv, output int bp, output int bi);
        f = 1'b0; bv = 0; bp = 0; bi = 0;
        for (int i = 0; i < n; i++) begin
            if (v[i] > thr && (!f || v[i] > bv)) begin
                f = 1'b1; bv = v[i]; bp = p[i]; bi = i;
            end
        end
    endfunction

    // Called at a negedge: present tv/tp, raise start, queue the expectation.
    task automatic issue(input int thr);
        exp_t e;
        logic f;
        int bv, bp, bi;
        for (int i = 0; i < 8; i++) begin
            val[i*3 +: 3] = tv[i][2:0];
            pld[i]        = tp[i][0];
        end
        thres = thr[2:0];
        start = 1'b1;
        ref_scan(8, tv, tp, thr, f, bv, bp, bi);
        e.st = cyc + 1; e.dn = cyc + 1 + S;
        e.f = f; e.v = bv; e.p = bp; e.i = bi;
        q.push_back(e);
        $display("[TB] scan start edge %0d thr=%0d vals=%0d%0d%0d%0d%0d%0d%0d%0d exp found=%0d val=%0d idx=%0d",
                 e.st, thr, tv[0], tv[1], tv[2], tv[3], tv[4], tv[5], tv[6], tv[7], f, bv, bi);
    endtask

    // gap=0 leaves the caller positioned so the next issue lands in DONE.
    task automatic scan_one(input int thr, input int gap);
        @(negedge clk);
        issue(thr);
        @(negedge clk);
        start = 1'b0;
        repeat (S - 1 + gap) @(negedge clk);
    endtask

    task automatic set_vals(input int a0, a1, a2, a3, a4, a5, a6, a7);
        tv[0] = a0; tv[1] = a1; tv[2] = a2; tv[3] = a3;
        tv[4] = a4; tv[5] = a5; tv[6] = a6; tv[7] = a7;
        for (int i = 0; i < 8; i++) tp[i] = $urandom_range(0, 1);
    endtask

    task automatic randomize_vals();
        for (int i = 0; i < 8; i++) begin
            tv[i] = $urandom_range(0, 7);
            tp[i] = $urandom_range(0, 1);
        end
    endtask

    // Directed run of the CH_N=5/PAR=2 and CH_N=8/PAR=8 instances.
    task automatic sec_run(input int thr);
        logic f5e, f8e;
        int v5e, p5e, i5e, v8e, p8e, i8e;
        int e0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            val8[i*3 +: 3] = tv[i][2:0];
            pld8[i]        = tp[i][0];
            if (i < 5) begin
                val5[i*3 +: 3] = tv[i][2:0];
                pld5[i]        = tp[i][0];
            end
        end
        thres2 = thr[2:0];
        s2 = 1'b1;
        e0 = cyc + 1;
        ref_scan(5, tv, tp, thr, f5e, v5e, p5e, i5e);
        ref_scan(8, tv, tp, thr, f8e, v8e, p8e, i8e);
        $display("[TB] sec scan edge %0d thr=%0d exp5 found=%0d val=%0d idx=%0d exp8 found=%0d val=%0d idx=%0d",
                 e0, thr, f5e, v5e, i5e, f8e, v8e, i8e);
        @(negedge clk);
        s2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("p8_busy", int'(b8), int'(k == 0));
            chk("p8_done", int'(d8), int'(k == 1));
            chk("c5_busy", int'(b5), int'(k <= 2));
            chk("c5_done", int'(d5), int'(k == 3));
            if (k == 1) begin
                chk("p8_found", int'(f8), int'(f8e));
                chk("p8_val", int'(v8o), v8e);
                chk("p8_pld", int'(p8o), p8e);
                chk("p8_idx", int'(i8o), i8e);
            end
            if (k == 3) begin
                chk("c5_found", int'(f5), int'(f5e));
                chk("c5_val", int'(v5o), v5e);
                chk("c5_pld", int'(p5o), p5e);
                chk("c5_idx", int'(i5o), i5e);
            end
            @(negedge clk);
        end
    endtask

    // Monitor for the main instance: busy every cycle, results on o_done,
    // held outputs between dones, zeros under reset.
    initial begin
        exp_t e;
        logic h_f;
        int h_v, h_p, h_i;
        logic exp_busy;
        h_f = 1'b0; h_v = 0; h_p = 0; h_i = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rstn) begin
                chk("rst_outputs", int'({busy, done, found, oval, opld, oidx}), 0);
                h_f = 1'b0; h_v = 0; h_p = 0; h_i = 0;
            end else begin
                exp_busy = (q.size() > 0) && (cyc >= q[0].st) && (cyc < q[0].dn);
                chk("busy", int'(busy), int'(exp_busy));
                if (done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("done_cycle", cyc, e.dn);
                        chk("found", int'(found), int'(e.f));
                        chk("val", int'(oval), e.v);
                        chk("pld", int'(opld), e.p);
                        chk("idx", int'(oidx), e.i);
                        $display("[TB] done cycle %0d found=%0d val=%0d pld=%0d idx=%0d",
                                 cyc, found, oval, opld, oidx);
                        h_f = e.f; h_v = e.v; h_p = e.p; h_i = e.i;
                    end
                end else begin
                    if (q.size() > 0 && cyc >= q[0].dn) begin
                        chk("missing_done", 0, 1);
                        void'(q.pop_front());
                    end
                    chk("held_result", int'({found, oval, opld, oidx}),
                        int'({h_f, h_v[2:0], h_p[0], h_i[2:0]}));
                end
            end
        end
    end

    // Fallback bound so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Example vector, with a start pulse while busy that must be ignored.
        set_vals(1, 5, 3, 5, 0, 2, 7, 7);
        @(negedge clk);
        issue(0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);

        // Back-to-back starts in the DONE cycle.
        set_vals(4, 4, 6, 4, 4, 6, 4, 4);
        scan_one(0, 0);
        set_vals(4, 4, 4, 4, 4, 4, 4, 4);
        scan_one(0, 0);
        set_vals(3, 1, 0, 2, 3, 3, 1, 2);
        scan_one(3, 1);
        scan_one(2, 2);
        set_vals(0, 0, 0, 0, 0, 0, 0, 7);
        scan_one(6, 1);

        // Reset in the middle of a scan: no done may follow.
        randomize_vals();
        @(negedge clk);
        issue(0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        q.delete();
        $display("[TB] reset asserted mid-scan at cycle %0d", cyc);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        // Fresh scan after reset, then random traffic.
        set_vals(2, 7, 1, 7, 0, 3, 5, 6);
        scan_one(1, 1);
        for (int n = 0; n < 40; n++) begin
            randomize_vals();
            scan_one($urandom_range(0, 7), $urandom_range(0, 2));
        end
        repeat (3) @(negedge clk);

        // Partial last group and single-step instances.
        set_vals(1, 1, 1, 1, 6, 0, 0, 0);
        sec_run(0);
        set_vals(1, 5, 3, 5, 0, 2, 7, 7);
        sec_run(0);
        set_vals(3, 3, 2, 3, 3, 3, 0, 1);
        sec_run(3);
        for (int n = 0; n < 6; n++) begin
            randomize_vals();
            sec_run($urandom_range(0, 6));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/max_scanner.md
# max_scanner

Sequential, parametrised max-finder that scans `CH_N` value/payload channels `PAR` channels per cycle and returns the winner's value, payload and index. A winner must be strictly above a per-scan threshold. It trades latency for area relative to a fully combinational tree. It sits in front of interrupt-priority and arbitration logic, where many channels must be ranked without a wide single-cycle comparator tree.

## Interface
- `CH_N`, 8, number of channels (≥1)
- `VAL_W`, 3, value width (≥1)
- `PLD_W`, 1, payload width (≥1)
- `PAR`, 2, channels compared per scan cycle (1..`CH_N`)
- `IDX_W`, derived, `max(1, $clog2(CH_N))`, index width (localparam)

- `clk` in 1: the single clock; all state on rising edge
- `rstn` in 1: synchronous, active-low reset
- `i_start` in 1: request a new scan; accepted only when `o_busy`=0
- `i_thres` in `VAL_W`: threshold, captured on accepted start
- `i_val` in `CH_N`×`VAL_W`: packed channel values
- `i_pld` in `CH_N`×`PLD_W`: packed channel payloads
- `o_busy` out 1: scan in progress
- `o_done` out 1: single-cycle pulse; result valid
- `o_found` out 1: some channel value > threshold
- `o_val` out `VAL_W`: winning value (0 if not found)
- `o_pld` out `PLD_W`: winning payload (0 if not found)
- `o_idx` out `IDX_W`: winning channel index (0 if not found)

## Operation
- `S = ceil(CH_N/PAR)` scan steps. Group `g` covers channels `g*PAR .. min(g*PAR+PAR, CH_N)-1`. Lanes past `CH_N` in the last group are ignored.
- FSM states: IDLE, SCAN, DONE.
  - IDLE → SCAN on `i_start`: latch `i_thres` into running best value, clear found flag, set group counter to 0.
  - SCAN: each cycle sample `i_val`/`i_pld` of the current group only. Find the group max; on a tie the lowest index wins. Replace the running best (value, payload, absolute index, found=1) only if group max > running best. The comparison is strict, so earlier channels win cross-group ties and values equal to the threshold never win. Increment the counter; after group `S-1`, go to DONE.
  - DONE: assert `o_done`. Result registers load in the transition into DONE.
    - Found: running best.
    - Not found: `o_found`=0, `o_val`/`o_pld`/`o_idx`=0.
  - DONE → SCAN if `i_start`, else → IDLE.
- `i_start` while in SCAN is ignored (no queueing).
- Inputs are not snapshotted. Each group reflects `i_val`/`i_pld` as sampled in that group's scan cycle, and channels already scanned are not revisited.
- Result outputs hold their value from the DONE cycle until the next DONE or reset.
- Arithmetic: all comparisons unsigned, `VAL_W` bits. The group counter is wide enough for `S-1`. Index = `g*PAR + lane`, truncated to `IDX_W`; it is always < `CH_N`.

## Timing
- Reset (`rstn`=0 at a rising edge): state IDLE, `o_busy`=0, `o_done`=0, `o_found`=0, `o_val`=0, `o_pld`=0, `o_idx`=0, counter=0. Reset mid-scan aborts the scan; no `o_done` follows.
- `o_busy`=1 exactly in SCAN (registered state decode). It is 0 in IDLE and DONE.
- Start sampled high at edge T: SCAN during cycles T+1..T+S, `o_done`=1 in cycle T+S+1 with results valid in the same cycle.
- Back-to-back: `i_start` in the DONE cycle starts the next scan immediately. The throughput is one result per `S+1` cycles.
- `PAR ≥ CH_N`: `S`=1, so `o_done` follows start by 2 cycles.

## Test plan
- CH_N=8, PAR=2, VAL_W=3, vals (idx0..7)=[1,5,3,5,0,2,7,7], thres=0, start at T → `o_busy` high T+1..T+4; `o_done` at T+5 only; found=1, val=7, idx=6, pld=pld[6].
- Tie rule: all vals=4 except idx2=idx5=6, thres=0 → idx=2. All vals=4, thres=0 → idx=0, val=4.
- Threshold: all vals ≤3, thres=3 → found=0, val=0, pld=0, idx=0. Same vals with thres=2 → the first 3 wins.
- Handshake: `i_start` pulsed at T+2 (busy) is ignored, with no change to the T+5 result. `i_start` held during the DONE cycle T+5 → new `o_done` at exactly T+10; outputs stay stable between dones.
- Reset mid-scan: `rstn`=0 at T+2 → from the next cycle all outputs 0, state IDLE, no `o_done` ever. After release, a fresh start completes normally.
- Partial group: CH_N=5, PAR=2, vals=[1,1,1,1,6], thres=0 → 3 scan cycles, `o_done` at T+4, val=6, idx=4. Also PAR=8, CH_N=8 → `o_done` at T+2.
